// File: rtl/cpu_iob_pkg.sv
// cpu_iob_pkg: shared constants, types and lane helpers for the CPU-to-IOb load/store unit
package cpu_iob_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WDRAIN, READ, RDONE} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } wb_entry_t;

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return f3[1] ? |a : f3[0] & a[0];
    endfunction

    function automatic logic [3:0] strb_of(input logic [2:0] f3, input logic [1:0] a);
        return f3[1] ? 4'b1111 : f3[0] ? 4'b0011 << a : 4'b0001 << a;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
        return f3[1] ? d : f3[0] ? {2{d[15:0]}} : {4{d[7:0]}};
    endfunction

    // f3[2] selects zero extension (BU/HU)
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] s;
        s = d >> {a, 3'b000};
        return f3[1] ? d : f3[0] ? {{16{s[15] & ~f3[2]}}, s[15:0]} : {{24{s[7] & ~f3[2]}}, s[7:0]};
    endfunction

endpackage

// File: rtl/cpu_iob_wbuf.sv
// cpu_iob_wbuf: posted write FIFO with occupancy count, head and next-head views
module cpu_iob_wbuf
    import cpu_iob_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  wb_entry_t                din,
    input  logic                     pop,
    output wb_entry_t                head,
    output wb_entry_t                head_nxt,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    wb_entry_t mem [DEPTH];
    logic [AW-1:0] wp, rp;

    assign head     = mem[rp];
    assign head_nxt = mem[rp + AW'(1)];
    assign full     = count == (AW+1)'(DEPTH);
    assign empty    = count == '0;

    // storage array carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;

    // pointers and occupancy, cleared asynchronously to discard buffered writes
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= push ? wp + AW'(1) : wp;
            rp    <= pop ? rp + AW'(1) : rp;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end

endmodule

// File: rtl/cpu_iob_lsu.sv
// cpu_iob_lsu: load/store bridge from the CPU memory stage to the IOb bus with posted writes and timeout guard
module cpu_iob_lsu
    import cpu_iob_pkg::*;
#(
    parameter int FE_ADDR_W      = 32,
    parameter int FE_DATA_W      = 32,
    parameter int WBUF_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic [2:0]           Funct3,
    input  logic [FE_ADDR_W-1:0] DataAdr,
    input  logic [31:0]          WriteData,
    output logic [31:0]          ReadData,
    output logic                 Stall,
    output logic                 misalign_o,
    output logic                 bus_err_o,
    input  logic                 err_clr_i,
    output logic                 iob_valid_o,
    output logic [FE_ADDR_W-1:0] iob_addr_o,
    output logic [31:0]          iob_wdata_o,
    output logic [3:0]           iob_wstrb_o,
    input  logic [31:0]          iob_rdata_i,
    input  logic                 iob_ready_i
);
    localparam int CW = $clog2(WBUF_DEPTH);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    if (FE_DATA_W != 32 || FE_ADDR_W > 32 || FE_ADDR_W < 3 || WBUF_DEPTH < 2 ||
        (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_param_check
        $fatal(1, "cpu_iob_lsu: unsupported parameter set");
    end

    state_t        state, state_nxt;
    wb_entry_t     wb_in, head, head_nxt, issue_e;
    logic [CW:0]   wb_count;
    logic          wb_full, wb_empty, wb_push, wb_pop;
    logic          mis, st_ok, ld_ok, done, tmo, issue_w, issue_r;
    logic [TW-1:0] tcnt;
    logic [31:0]   rdata_q;

    assign mis     = misaligned(Funct3, DataAdr[1:0]);
    assign st_ok   = MemWrite & ~mis;
    assign ld_ok   = MemRead & ~mis;
    assign wb_push = st_ok & ~wb_full;
    assign done    = iob_valid_o & iob_ready_i;
    assign tmo     = TIMEOUT_CYCLES != 0 && iob_valid_o && !iob_ready_i && tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign wb_pop  = state == WDRAIN && (done || tmo);
    assign issue_w = state_nxt == WDRAIN && (state == IDLE || wb_pop);
    assign issue_r = state == IDLE && state_nxt == READ;
    assign issue_e = state == IDLE ? head : head_nxt;

    assign wb_in = '{addr:  32'({DataAdr[FE_ADDR_W-1:2], 2'b00}),
                     wdata: lane_data(Funct3, WriteData),
                     wstrb: strb_of(Funct3, DataAdr[1:0])};

    assign Stall      = reset & (st_ok & wb_full | ld_ok & state != RDONE);
    assign misalign_o = reset & (MemRead | MemWrite) & mis;
    assign ReadData   = state == RDONE ? rdata_q : '0;

    cpu_iob_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk      (clk),
        .reset    (reset),
        .push     (wb_push),
        .din      (wb_in),
        .pop      (wb_pop),
        .head     (head),
        .head_nxt (head_nxt),
        .count    (wb_count),
        .full     (wb_full),
        .empty    (wb_empty)
    );

    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nxt;

    // writes drain before any read; chaining uses the next entry only when it is already stored
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = !wb_empty ? WDRAIN : ld_ok ? READ : IDLE;
            WDRAIN:  state_nxt = wb_pop ? (wb_count > (CW+1)'(1) ? WDRAIN : IDLE) : WDRAIN;
            READ:    state_nxt = done || tmo ? RDONE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    // registered IOb request, held stable until completion or timeout
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            iob_valid_o <= 1'b0;
            iob_addr_o  <= '0;
            iob_wdata_o <= '0;
            iob_wstrb_o <= '0;
        end else if (issue_w) begin
            iob_valid_o <= 1'b1;
            iob_addr_o  <= FE_ADDR_W'(issue_e.addr);
            iob_wdata_o <= issue_e.wdata;
            iob_wstrb_o <= issue_e.wstrb;
        end else if (issue_r) begin
            iob_valid_o <= 1'b1;
            iob_addr_o  <= {DataAdr[FE_ADDR_W-1:2], 2'b00};
            iob_wstrb_o <= 4'b0000;
        end else if (done || tmo) begin
            iob_valid_o <= 1'b0;
        end

    // stall-cycle counter, sticky error flag and load result capture
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            tcnt      <= '0;
            bus_err_o <= 1'b0;
            rdata_q   <= '0;
        end else begin
            tcnt      <= iob_valid_o && !iob_ready_i && !tmo ? tcnt + TW'(1) : '0;
            bus_err_o <= tmo | bus_err_o & ~err_clr_i;
            if (state == READ && (done || tmo))
                rdata_q <= done ? load_ext(Funct3, DataAdr[1:0], iob_rdata_i) : '0;
        end

endmodule

// File: tb/tb_cpu_iob_lsu.sv
// tb_cpu_iob_lsu: directed self-checking bench for the load/store bridge
module tb_cpu_iob_lsu;
    import cpu_iob_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead, MemWrite, err_clr_i, iob_ready_i;
    logic [2:0]  Funct3;
    logic [31:0] DataAdr, WriteData, ReadData, iob_addr_o, iob_wdata_o, iob_rdata_i;
    logic        Stall, misalign_o, bus_err_o, iob_valid_o;
    logic [3:0]  iob_wstrb_o;
    int          n_run = 0;
    int          n_fail = 0;

    cpu_iob_lsu #(.FE_ADDR_W(32), .FE_DATA_W(32), .WBUF_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .Funct3      (Funct3),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .Stall       (Stall),
        .misalign_o  (misalign_o),
        .bus_err_o   (bus_err_o),
        .err_clr_i   (err_clr_i),
        .iob_valid_o (iob_valid_o),
        .iob_addr_o  (iob_addr_o),
        .iob_wdata_o (iob_wdata_o),
        .iob_wstrb_o (iob_wstrb_o),
        .iob_rdata_i (iob_rdata_i),
        .iob_ready_i (iob_ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        MemRead   = rd;
        MemWrite  = wr;
        Funct3    = f3;
        DataAdr   = a;
        WriteData = d;
    endtask

    task automatic idle();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        req(0, 0, F3_W, 32'h0, 32'h0);
        err_clr_i   = 1'b0;
        iob_ready_i = 1'b0;
        iob_rdata_i = 32'h0;
        #12;
        chk("rst_valid", iob_valid_o, 0);
        chk("rst_addr", iob_addr_o, 0);
        chk("rst_wdata", iob_wdata_o, 0);
        chk("rst_wstrb", iob_wstrb_o, 0);
        chk("rst_rdata", ReadData, 0);
        chk("rst_stall", Stall, 0);
        chk("rst_mis", misalign_o, 0);
        chk("rst_err", bus_err_o, 0);
        cyc();
        reset = 1'b1;

        // word store, slave accepts on the third valid cycle
        req(0, 1, F3_W, 32'h1000, 32'hDEADBEEF);
        mid(); chk("sw_stall", Stall, 0);
        cyc(); idle();
        mid(); chk("sw_valid_pre", iob_valid_o, 0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            iob_ready_i = i == 2;
            mid();
            chk("sw_valid", iob_valid_o, 1);
            chk("sw_addr", iob_addr_o, 32'h1000);
            chk("sw_wstrb", iob_wstrb_o, 4'hF);
            chk("sw_wdata", iob_wdata_o, 32'hDEADBEEF);
            chk("sw_stall_hold", Stall, 0);
            cyc();
        end
        iob_ready_i = 1'b0;
        mid(); chk("sw_done", iob_valid_o, 0);
        cyc();

        // byte store then signed byte load to the same address
        req(0, 1, F3_B, 32'h2003, 32'h000000A5);
        cyc();
        req(1, 0, F3_B, 32'h2003, 32'h0);
        mid(); chk("lb_stall_wait", Stall, 1);
        cyc();
        iob_ready_i = 1'b1;
        mid();
        chk("sb_valid", iob_valid_o, 1);
        chk("sb_addr", iob_addr_o, 32'h2000);
        chk("sb_wstrb", iob_wstrb_o, 4'h8);
        chk("sb_wdata", iob_wdata_o, 32'hA5A5A5A5);
        chk("lb_stall_drain", Stall, 1);
        cyc();
        iob_ready_i = 1'b0;
        mid(); chk("lb_gap_valid", iob_valid_o, 0);
        cyc();
        iob_ready_i = 1'b1;
        iob_rdata_i = 32'hA5000000;
        mid();
        chk("lb_valid", iob_valid_o, 1);
        chk("lb_wstrb", iob_wstrb_o, 4'h0);
        chk("lb_addr", iob_addr_o, 32'h2000);
        chk("lb_stall_bus", Stall, 1);
        cyc();
        iob_ready_i = 1'b0;
        mid();
        chk("lb_data", ReadData, 32'hFFFFFFA5);
        chk("lb_stall_done", Stall, 0);
        cyc(); idle();
        mid(); chk("lb_data_clear", ReadData, 0);
        cyc();

        // unsigned byte load at minimum latency
        req(1, 0, F3_BU, 32'h2003, 32'h0);
        mid(); chk("lbu_stall0", Stall, 1);
        cyc();
        iob_ready_i = 1'b1;
        mid(); chk("lbu_valid", iob_valid_o, 1);
        cyc();
        iob_ready_i = 1'b0;
        mid();
        chk("lbu_data", ReadData, 32'h000000A5);
        chk("lbu_stall2", Stall, 0);
        cyc(); idle();
        cyc();

        // five stores against a four-entry buffer with ready held low
        for (int i = 0; i < 5; i++) begin
            req(0, 1, F3_W, 32'h100 + 4 * i, i + 1);
            mid(); chk("fill_stall", Stall, i == 4);
            if (i < 4) cyc();
        end
        cyc();
        iob_ready_i = 1'b1;
        for (int j = 0; j < 5; j++) begin
            mid();
            if (j < 2) chk("full_stall", Stall, j == 0);
            chk("drain_valid", iob_valid_o, 1);
            chk("drain_addr", iob_addr_o, 32'h100 + 4 * j);
            chk("drain_wdata", iob_wdata_o, j + 1);
            cyc();
            if (j == 1) idle();
        end
        iob_ready_i = 1'b0;
        mid(); chk("drain_end", iob_valid_o, 0);
        cyc();

        // misaligned halfword load
        req(1, 0, F3_H, 32'h3001, 32'h0);
        mid();
        chk("mis_pulse", misalign_o, 1);
        chk("mis_stall", Stall, 0);
        chk("mis_rdata", ReadData, 0);
        chk("mis_valid", iob_valid_o, 0);
        cyc(); idle();
        mid();
        chk("mis_clear", misalign_o, 0);
        chk("mis_novalid", iob_valid_o, 0);
        cyc();

        // word load that never receives ready
        req(1, 0, F3_W, 32'h4000, 32'h0);
        mid(); chk("to_stall0", Stall, 1);
        cyc();
        for (int k = 1; k <= 8; k++) begin
            mid(); chk("to_valid", iob_valid_o, 1);
            cyc();
        end
        mid();
        chk("to_dropped", iob_valid_o, 0);
        chk("to_err", bus_err_o, 1);
        chk("to_rdata", ReadData, 0);
        chk("to_stall", Stall, 0);
        cyc(); idle();
        err_clr_i = 1'b1;
        mid(); chk("err_sticky", bus_err_o, 1);
        cyc();
        err_clr_i = 1'b0;
        mid(); chk("err_cleared", bus_err_o, 0);
        cyc();

        // reset while a write is on the bus with more buffered
        for (int i = 0; i < 3; i++) begin
            req(0, 1, F3_W, 32'h500 + 4 * i, 32'h55 + i);
            cyc();
        end
        idle();
        mid(); chk("pre_rst_valid", iob_valid_o, 1);
        reset = 1'b0;
        #1;
        chk("arst_valid", iob_valid_o, 0);
        chk("arst_addr", iob_addr_o, 0);
        chk("arst_wdata", iob_wdata_o, 0);
        chk("arst_wstrb", iob_wstrb_o, 0);
        chk("arst_stall", Stall, 0);
        chk("arst_rdata", ReadData, 0);
        cyc();
        reset = 1'b1;
        iob_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mid(); chk("post_rst_valid", iob_valid_o, 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
